multicycle_controller: RTL and testbench

- Moore-style FSM controller for the multicycle RV32I datapath: one shared ALU, one unified instruction/data memory, and instruction (IR), old-PC and ALUOut holding registers.
- Sequences each instruction over 3-5 cycles and drives every datapath select and write enable.
- Replaces the single-cycle decode path when the core is built in multicycle configuration; the datapath instantiates it directly.

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for the multicycle RV32I datapath: walks each
// instruction through 3-5 states and drives every datapath select and enable.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [2:0]         ImmSrc,
  output logic [3:0]         ALUControl,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRWB   = 4'd12,
    LUI      = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  state_t state, nextState;
  aluop_t aluOp;
  logic   pcWriteRaw, memWriteRaw, irWriteRaw, regWriteRaw, illegalRaw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = FETCH;
    pcWriteRaw  = 1'b0;
    AdrSrc      = 1'b0;
    memWriteRaw = 1'b0;
    irWriteRaw  = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    regWriteRaw = 1'b0;
    aluOp       = ALUOP_ADD;
    illegalRaw  = 1'b0;
    case (state)
      FETCH: begin
        nextState  = DECODE;
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcWriteRaw = 1'b1;
      end
      DECODE: begin
        // PC-relative target is precomputed here so BRANCH can use ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nextState = MEMADR;
          7'b0110011:             nextState = EXECR;
          7'b0010011:             nextState = EXECI;
          7'b1100011:             nextState = BRANCH;
          7'b1101111:             nextState = JAL;
          7'b1100111:             nextState = JALR;
          7'b0110111:             nextState = LUI;
          default: begin
            nextState  = FETCH;
            illegalRaw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        nextState = op[5] ? MEMWRITE : MEMREAD;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
      end
      MEMREAD: begin
        nextState = MEMWB;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECR: begin
        nextState = ALUWB;
        ALUSrcA   = 2'b10;
        aluOp     = ALUOP_FUNCT;
      end
      EXECI: begin
        nextState = ALUWB;
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluOp     = ALUOP_FUNCT;
      end
      ALUWB: regWriteRaw = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        aluOp      = ALUOP_SUB;
        pcWriteRaw = (funct3[2:1] == 2'b00) && (Zero ^ funct3[0]);
      end
      JAL: begin
        nextState  = ALUWB;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pcWriteRaw = 1'b1;
      end
      JALR: begin
        nextState  = JALRWB;
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        pcWriteRaw = 1'b1;
      end
      JALRWB: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        regWriteRaw = 1'b1;
      end
      LUI: begin
        nextState = ALUWB;
        ALUSrcA   = 2'b11;
        ALUSrcB   = 2'b01;
      end
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 4'b0000;
    case (aluOp)
      ALUOP_ADD: ALUControl = 4'b0000;
      ALUOP_SUB: ALUControl = 4'b0001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 4'b0001 : 4'b0000;
          3'b001:  ALUControl = 4'b0110;
          3'b010:  ALUControl = 4'b0101;
          3'b011:  ALUControl = 4'b1001;
          3'b100:  ALUControl = 4'b0100;
          3'b101:  ALUControl = funct7b5 ? 4'b1000 : 4'b0111;
          3'b110:  ALUControl = 4'b0011;
          default: ALUControl = 4'b0010;
        endcase
      end
    endcase
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      7'b0100011: ImmSrc = 3'b001;
      7'b1100011: ImmSrc = 3'b010;
      7'b1101111: ImmSrc = 3'b011;
      7'b0110111: ImmSrc = 3'b100;
      default:    ImmSrc = 3'b000;
    endcase
  end

  // Reset masks the enables directly so FETCH's PC/IR loads cannot fire while held
  assign PCWrite  = pcWriteRaw  & ~reset;
  assign MemWrite = memWriteRaw & ~reset;
  assign IRWrite  = irWriteRaw  & ~reset;
  assign RegWrite = regWriteRaw & ~reset;
  assign Illegal  = illegalRaw  & ~reset;
  assign State    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic [3:0] State;

  typedef struct packed {
    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic [2:0] immSrc;
    logic [3:0] aluControl;
    logic       illegal;
  } outs_t;

  outs_t obs;
  int    cmpCount = 0;
  int    errCount = 0;
  int    expSeq[$];

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, Illegal};

  function automatic logic isLegal(input logic [6:0] o);
    return o inside {OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
  endfunction

  function automatic logic [3:0] functCode(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
    logic [3:0] table3 [8];
    table3 = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
    if (f3 == 3'd0 && o[5] && f7) return 4'd1;
    if (f3 == 3'd5 && f7)         return 4'd8;
    return table3[f3];
  endfunction

  // Expected output vector for a given state number under the current inputs
  function automatic outs_t expOut(input int st);
    outs_t e;
    e = '0;
    case (op)
      OP_SW:   e.immSrc = 3'd1;
      OP_BR:   e.immSrc = 3'd2;
      OP_JAL:  e.immSrc = 3'd3;
      OP_LUI:  e.immSrc = 3'd4;
      default: e.immSrc = 3'd0;
    endcase
    case (st)
      0:  begin e.irWrite = 1; e.aluSrcB = 2; e.resultSrc = 2; e.pcWrite = 1; end
      1:  begin e.aluSrcA = 1; e.aluSrcB = 1; e.illegal = !isLegal(op); end
      2:  begin e.aluSrcA = 2; e.aluSrcB = 1; end
      3:  e.adrSrc = 1;
      4:  begin e.resultSrc = 1; e.regWrite = 1; end
      5:  begin e.adrSrc = 1; e.memWrite = 1; end
      6:  begin e.aluSrcA = 2; e.aluControl = functCode(op, funct3, funct7b5); end
      7:  begin e.aluSrcA = 2; e.aluSrcB = 1; e.aluControl = functCode(op, funct3, funct7b5); end
      8:  e.regWrite = 1;
      9:  begin
            e.aluSrcA = 2; e.aluControl = 4'd1;
            e.pcWrite = (funct3 == 3'd0) ? Zero : (funct3 == 3'd1) ? !Zero : 1'b0;
          end
      10: begin e.aluSrcA = 1; e.aluSrcB = 2; e.pcWrite = 1; end
      11: begin e.aluSrcA = 2; e.aluSrcB = 1; e.resultSrc = 2; e.pcWrite = 1; end
      12: begin e.aluSrcA = 1; e.aluSrcB = 2; e.resultSrc = 2; e.regWrite = 1; end
      13: begin e.aluSrcA = 3; e.aluSrcB = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic buildSeq(input logic [6:0] o);
    case (o)
      OP_LW:   expSeq = '{0, 1, 2, 3, 4};
      OP_SW:   expSeq = '{0, 1, 2, 5};
      OP_R:    expSeq = '{0, 1, 6, 8};
      OP_I:    expSeq = '{0, 1, 7, 8};
      OP_BR:   expSeq = '{0, 1, 9};
      OP_JAL:  expSeq = '{0, 1, 10, 8};
      OP_JALR: expSeq = '{0, 1, 11, 12};
      OP_LUI:  expSeq = '{0, 1, 13, 8};
      default: expSeq = '{0, 1};
    endcase
  endtask

  task automatic checkOutput(input string tag, input int expState, input outs_t expVec);
    cmpCount++;
    assert (State === 4'(expState)) else begin
      errCount++;
      $error("[TB] FAIL %s state: observed %0d expected %0d", tag, State, expState);
    end
    cmpCount++;
    assert (obs === expVec) else begin
      errCount++;
      $error("[TB] FAIL %s outputs: observed %h expected %h", tag, obs, expVec);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    buildSeq(o);
  endtask

  // Checks the first nSteps states, advancing one clock after each
  task automatic runInstr(input string tag, input int nSteps);
    for (int i = 0; i < nSteps && i < expSeq.size(); i++) begin
      #1 checkOutput(tag, expSeq[i], expOut(expSeq[i]));
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    outs_t rstVec;
    logic [6:0] rop;
    reset = 1'b1;
    applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0);
    #3;
    rstVec = expOut(0);
    rstVec.pcWrite = 0; rstVec.irWrite = 0;
    checkOutput("reset", 0, rstVec);
    @(posedge clk);
    #2 reset = 1'b0;

    applyStimulus(OP_LW,   3'd2, 1'b0, 1'b0); runInstr("lw", 99);
    applyStimulus(OP_SW,   3'd2, 1'b0, 1'b1); runInstr("sw", 99);
    applyStimulus(OP_R,    3'd0, 1'b1, 1'b0); runInstr("sub", 99);
    applyStimulus(OP_I,    3'd0, 1'b1, 1'b0); runInstr("addi", 99);
    applyStimulus(OP_I,    3'd5, 1'b1, 1'b0); runInstr("srai", 99);
    applyStimulus(OP_BR,   3'd0, 1'b0, 1'b1); runInstr("beq_taken", 99);
    applyStimulus(OP_BR,   3'd0, 1'b0, 1'b0); runInstr("beq_not", 99);
    applyStimulus(OP_BR,   3'd1, 1'b0, 1'b0); runInstr("bne_taken", 99);
    applyStimulus(OP_BR,   3'd4, 1'b0, 1'b1); runInstr("blt_unsup", 99);
    applyStimulus(OP_JAL,  3'd0, 1'b0, 1'b0); runInstr("jal", 99);
    applyStimulus(OP_JALR, 3'd0, 1'b0, 1'b0); runInstr("jalr", 99);
    applyStimulus(OP_LUI,  3'd3, 1'b1, 1'b0); runInstr("lui", 99);
    applyStimulus(7'b1111111, 3'd0, 1'b0, 1'b0); runInstr("illegal", 99);

    for (int n = 0; n < 60; n++) begin
      logic [6:0] ops [8];
      int pick;
      ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
      pick = int'($urandom_range(0, 8));
      if (pick == 8) begin
        rop = 7'($urandom);
        while (isLegal(rop)) rop = 7'($urandom);
      end else begin
        rop = ops[pick];
      end
      applyStimulus(rop, 3'($urandom), 1'($urandom), 1'($urandom));
      runInstr("random", 99);
    end

    // Reset dropped in while a load sits in MEMREAD
    applyStimulus(OP_LW, 3'd2, 1'b0, 1'b0);
    runInstr("lw_pre_reset", 3);
    #1 checkOutput("lw_memread", 3, expOut(3));
    reset = 1'b1;
    #1 checkOutput("reset_async", 0, rstVec);
    @(posedge clk);
    #2 checkOutput("reset_held", 0, rstVec);
    reset = 1'b0;
    #1 checkOutput("reset_release", 0, expOut(0));
    @(posedge clk);
    #2 checkOutput("post_reset_decode", 1, expOut(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
